prog_mem_arbiter: RTL

PROG_MEM_ARBITER -- requirements
Module: prog_mem_arbiter

---
 rtl/prog_mem_arbiter.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/prog_mem_arbiter.sv
// rtl/prog_mem_arbiter.sv - host/two-core program memory arbiter with LOAD mode (optional PMEM_ARB_LOCKWR_EN)
module prog_mem_arbiter #(
    parameter int DW = 18,
    parameter int AW = 12
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          h_req,
    input  logic          h_we,
    input  logic [AW-1:0] h_a,
    input  logic [DW-1:0] h_di,
    input  logic          h_lock,
    output logic          h_ack,
    output logic [DW-1:0] h_dq,
    output logic          h_err,
    input  logic          c0_req,
    input  logic [AW-1:0] c0_a,
    input  logic          c1_req,
    input  logic [AW-1:0] c1_a,
    output logic          c0_ack,
    output logic [DW-1:0] c0_dq,
    output logic          c1_ack,
    output logic [DW-1:0] c1_dq,
    output logic          loading,
    output logic [AW-1:0] m_a,
    output logic          m_we,
    output logic [DW-1:0] m_di,
    input  logic [DW-1:0] m_dq
);

    typedef enum logic {
        RUN  = 1'b0,
        LOAD = 1'b1
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic          last_c1;
    logic          h_elig;
    logic          c0_elig;
    logic          c1_elig;
    logic          gnt_h;
    logic          gnt_c0;
    logic          gnt_c1;
    logic          wr_reject;
    logic [AW-1:0] a_q;
    logic [DW-1:0] di_q;

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RUN;
        end else begin
            state <= state_nxt;
        end
    end

    // LOAD follows the host lock request, one edge later
    always_comb begin
        state_nxt = state;
        case (state)
            RUN:     if (h_lock)  state_nxt = LOAD;
            LOAD:    if (!h_lock) state_nxt = RUN;
            default: state_nxt = RUN;
        endcase
    end

    assign loading = (state == LOAD);

    // eligibility and grant: host first, then round-robin between cores (cores frozen in LOAD)
    always_comb begin
        h_elig  = rst_n & h_req & ~h_ack;
        c0_elig = rst_n & (state == RUN) & c0_req & ~c0_ack;
        c1_elig = rst_n & (state == RUN) & c1_req & ~c1_ack;
        gnt_h   = h_elig;
        gnt_c0  = ~h_elig & c0_elig & (~c1_elig | last_c1);
        gnt_c1  = ~h_elig & c1_elig & (~c0_elig | ~last_c1);
    end

`ifdef PMEM_ARB_LOCKWR_EN
    assign wr_reject = gnt_h & h_we & (state == RUN);

    // rejected host writes are flagged alongside their ack
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_err <= 1'b0;
        end else begin
            h_err <= wr_reject;
        end
    end
`else
    assign wr_reject = 1'b0;
    assign h_err     = 1'b0;
`endif

    // memory port: driven by the winner, otherwise holds the last address/data
    always_comb begin
        m_we = gnt_h & h_we & ~wr_reject;
        m_a  = a_q;
        m_di = di_q;
        if (gnt_h) begin
            m_a  = h_a;
            m_di = h_di;
        end else if (gnt_c0) begin
            m_a = c0_a;
        end else if (gnt_c1) begin
            m_a = c1_a;
        end
    end

    // remember the last driven address/data so idle cycles keep them stable
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q  <= '0;
            di_q <= '0;
        end else begin
            a_q  <= m_a;
            di_q <= m_di;
        end
    end

    // acks, read-data capture and round-robin pointer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_ack   <= 1'b0;
            c0_ack  <= 1'b0;
            c1_ack  <= 1'b0;
            h_dq    <= '0;
            c0_dq   <= '0;
            c1_dq   <= '0;
            last_c1 <= 1'b1;
        end else begin
            h_ack  <= gnt_h;
            c0_ack <= gnt_c0;
            c1_ack <= gnt_c1;
            if (gnt_h && !h_we) h_dq <= m_dq;
            if (gnt_c0) c0_dq <= m_dq;
            if (gnt_c1) c1_dq <= m_dq;
            if (gnt_c0) begin
                last_c1 <= 1'b0;
            end else if (gnt_c1) begin
                last_c1 <= 1'b1;
            end else if (state == LOAD && state_nxt == RUN) begin
                last_c1 <= 1'b1;
            end
        end
    end

endmodule
